// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: state encoding and default width.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_CALC = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: remainder, divisor and quotient registers with subtractor and comparator.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ldr,
    input  logic             ldb,
    input  logic             clrq,
    input  logic             setq,
    input  logic             subr,
    input  logic             incq,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic             ge,
    output logic             bz
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            b_q <= '0;
            q_q <= '0;
        end else begin
            if (ldr) begin
                r_q <= data_in;
            end else if (subr) begin
                r_q <= r_q - b_q;
            end
            if (ldb) begin
                b_q <= data_in;
            end
            // Divide-by-zero reports an all-ones quotient instead of clearing it.
            if (setq) begin
                q_q <= '1;
            end else if (clrq) begin
                q_q <= '0;
            end else if (incq) begin
                q_q <= q_q + WIDTH'(1);
            end
        end
    end

    always_comb begin
        r  = r_q;
        q  = q_q;
        ge = (r_q >= b_q);
        bz = (data_in == '0);
    end

endmodule

// File: rtl/div_repsub.sv
// Unsigned repeated-subtraction divider: controller FSM driving div_datapath.
// Optional DIV_CYCLE_COUNT_EN adds a 'cycles' output counting CALC edges.
module div_repsub
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
`ifdef DIV_CYCLE_COUNT_EN
    ,
    output logic [WIDTH-1:0] cycles
`endif
);

    state_e state_q, state_d;
    logic   ldr, ldb, clrq, setq, subr, incq;
    logic   ge, bz;
    logic   dz_q;

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .ldr     (ldr),
        .ldb     (ldb),
        .clrq    (clrq),
        .setq    (setq),
        .subr    (subr),
        .incq    (incq),
        .r       (remainder),
        .q       (quotient),
        .ge      (ge),
        .bz      (bz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ldb) begin
                dz_q <= bz;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ldr     = 1'b0;
        ldb     = 1'b0;
        clrq    = 1'b0;
        setq    = 1'b0;
        subr    = 1'b0;
        incq    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LDA;
            end
            S_LDA: begin
                ldr     = 1'b1;
                state_d = S_LDB;
            end
            S_LDB: begin
                ldb = 1'b1;
                if (bz) begin
                    setq    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    clrq    = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (ge) begin
                    subr = 1'b1;
                    incq = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) state_d = S_LDA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done        = (state_q == S_DONE);
        busy        = (state_q == S_LDA) || (state_q == S_LDB) || (state_q == S_CALC);
        div_by_zero = dz_q;
    end

`ifdef DIV_CYCLE_COUNT_EN
    logic [WIDTH-1:0] cycles_q;

    // Counts every CALC edge, including the one that exits to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else if (state_q == S_LDB) begin
            cycles_q <= '0;
        end else if (state_q == S_CALC) begin
            cycles_q <= cycles_q + WIDTH'(1);
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: directed operations against an arithmetic reference model.
module tb_div_repsub;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;
`ifdef DIV_CYCLE_COUNT_EN
    logic [W-1:0] cycles;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model of the operation in flight.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_q, m_r, m_cyc;
    logic         m_dz;
    int           m_lat;

    div_repsub #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
`ifdef DIV_CYCLE_COUNT_EN
        ,
        .cycles      (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Continuous check of results whenever the DUT claims them valid.
    always @(negedge clk) begin
        if (rst_n && done && m_valid) begin
            chk("model quotient", {16'd0, quotient}, {16'd0, m_q});
            chk("model remainder", {16'd0, remainder}, {16'd0, m_r});
            chk("model div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
            chk("model busy", {31'd0, busy}, 32'd0);
`ifdef DIV_CYCLE_COUNT_EN
            chk("model cycles", {16'd0, cycles}, {16'd0, m_cyc});
`endif
        end
    end

    // Issues start plus both operands; returns right after the divisor-load edge (k+2).
    task automatic launch(input logic [W-1:0] n, input logic [W-1:0] d);
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'hDEAD;
        @(posedge clk);
        m_q     = (d == 0) ? '1 : n / d;
        m_r     = (d == 0) ? n : n % d;
        m_dz    = (d == 0);
        m_cyc   = (d == 0) ? '0 : W'(n / d + 1);
        m_lat   = (d == 0) ? 2 : 3 + int'(n / d);
        m_valid = 1'b1;
        @(negedge clk);
        chk("done drops on start edge", {31'd0, done}, 32'd0);
        chk("busy in LDA", {31'd0, busy}, 32'd1);
        start   = 1'b0;
        data_in = n;
        @(posedge clk);
        @(negedge clk);
        data_in = d;
        @(posedge clk);
    endtask

    // Waits (bounded) for done, optionally pulsing start mid-CALC, and checks latency.
    task automatic finish_op(input bit pulse, input logic [W-1:0] lit_q,
                             input logic [W-1:0] lit_r);
        int edges;
        edges = 2;
        @(negedge clk);
        data_in = 16'h5A5A;
        while (!done && edges < m_lat + 10) begin
            start = pulse && (edges % 1000 == 10) && (edges + 3 < m_lat);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done reached", {31'd0, done}, 32'd1);
        chk("latency edges", edges, m_lat);
        chk("literal quotient", {16'd0, quotient}, {16'd0, lit_q});
        chk("literal remainder", {16'd0, remainder}, {16'd0, lit_r});
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #12;
        chk("reset quotient", {16'd0, quotient}, 32'd0);
        chk("reset remainder", {16'd0, remainder}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(16'd17, 16'd5);
        finish_op(1'b0, 16'd3, 16'd2);
        chk("17/5 dz", {31'd0, div_by_zero}, 32'd0);

        launch(16'd5, 16'd5);
        finish_op(1'b0, 16'd1, 16'd0);

        launch(16'd3, 16'd7);
        finish_op(1'b0, 16'd0, 16'd3);
`ifdef DIV_CYCLE_COUNT_EN
        chk("3/7 cycles", {16'd0, cycles}, 32'd1);
`endif

        launch(16'd42, 16'd0);
        finish_op(1'b0, 16'hFFFF, 16'd42);
        chk("42/0 dz", {31'd0, div_by_zero}, 32'd1);
`ifdef DIV_CYCLE_COUNT_EN
        chk("42/0 cycles", {16'd0, cycles}, 32'd0);
`endif

        launch(16'd65535, 16'd1);
        finish_op(1'b1, 16'd65535, 16'd0);

        // Abort 1000/3 mid-CALC with an asynchronous reset.
        launch(16'd1000, 16'd3);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("mid-calc busy", {31'd0, busy}, 32'd1);
        m_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort quotient", {16'd0, quotient}, 32'd0);
        chk("abort remainder", {16'd0, remainder}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after abort busy", {31'd0, busy}, 32'd0);

        launch(16'd100, 16'd7);
        finish_op(1'b0, 16'd14, 16'd2);

        // Back-to-back from DONE; launch checks that done drops on the start edge.
        launch(16'd200, 16'd9);
        finish_op(1'b0, 16'd22, 16'd2);

        repeat (3) @(negedge clk);
        chk("done held", {31'd0, done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
